// File: rtl/alu181_seq.sv
// Multi-cycle WIDTH-bit 74181-style ALU: one 4-bit slice per clock, LSB first,
// with the inter-slice carry held in a register. Valid/ready on both sides.
module alu181_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cn_out_n,
  output logic             aeqb
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // Reject widths that cannot be cut into whole 4-bit slices
  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("alu181_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [IDXW-1:0]   idx;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q, b_q, acc;
  logic [3:0]        s_q;
  logic              m_q;

  logic              accept;
  logic              last_slice;
  logic [3:0]        sa, sb, sx, sy, slice_f;
  logic [4:0]        sum;
  logic              carry_nx;
  logic [WIDTH-1:0]  acc_nx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake decode from registered state
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_slice = (idx == IDXW'(NSLICE - 1));
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (last_slice) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // One 74181 slice on the currently indexed nibble of the latched operands
  always_comb begin
    sa      = 4'(a_q >> {idx, 2'b00});
    sb      = 4'(b_q >> {idx, 2'b00});
    sx      = sa | (sb & {4{s_q[0]}}) | (~sb & {4{s_q[1]}});
    sy      = (sa & sb & {4{s_q[3]}}) | (sa & ~sb & {4{s_q[2]}});
    sum     = {1'b0, sx} + {1'b0, sy} + {4'b0000, carry_q};
    slice_f = m_q ? ~(sx ^ sy) : sum[3:0];
    carry_nx = sum[4];
    acc_nx  = acc;
    acc_nx[{idx, 2'b00} +: 4] = slice_f;
  end

  // Operand latch, slice sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      acc      <= '0;
      f        <= '0;
      cn_out_n <= 1'b1;
      aeqb     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      s_q     <= s;
      m_q     <= m;
      carry_q <= ~cn_n;
      idx     <= '0;
    end else if (state == ST_RUN) begin
      acc     <= acc_nx;
      carry_q <= carry_nx;
      if (last_slice) begin
        idx      <= '0;
        f        <= acc_nx;
        cn_out_n <= m_q ? 1'b1 : ~carry_nx;
        aeqb     <= &acc_nx;
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu181_seq.sv
// Directed bench for alu181_seq at WIDTH=8 with hand-computed expectations.
module tb_alu181_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b, f;
  logic [3:0]       s;
  logic             m, cn_n;
  logic             out_valid, out_ready;
  logic             cn_out_n, aeqb;

  int errors = 0;
  int checks = 0;

  alu181_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .m(m), .cn_n(cn_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cn_out_n(cn_out_n), .aeqb(aeqb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Step one clock; inputs driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result, check it, then leave DONE
  task automatic do_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                       input logic [3:0] vs, input logic vm, input logic vcn,
                       input logic [7:0] ef, input logic ecn, input logic eaeqb,
                       input bit consume);
    int lat;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = va; b = vb; s = vs; m = vm; cn_n = vcn; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); s = 4'($urandom); m = 1'($urandom); cn_n = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd3);
    check({tag, ".f"}, 32'(f), 32'(ef));
    check({tag, ".cn_out_n"}, 32'(cn_out_n), 32'(ecn));
    check({tag, ".aeqb"}, 32'(aeqb), 32'(eaeqb));
    check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    if (consume) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
      check({tag, ".idle_f_hold"}, 32'(f), 32'(ef));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; cn_n = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.f", 32'(f), 32'h00);
    check("rst.cn_out_n", 32'(cn_out_n), 32'd1);
    check("rst.aeqb", 32'(aeqb), 32'd0);

    // Arithmetic
    do_op("add_carry", 8'hF8, 8'h0A, 4'd9, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
    do_op("sub_cin",   8'h10, 8'h01, 4'd6, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    do_op("cmp_eq",    8'h5A, 8'h5A, 4'd6, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    do_op("ones",      8'h37, 8'hC2, 4'd3, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    do_op("dec_zero",  8'h00, 8'h99, 4'd15, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    do_op("dec",       8'h34, 8'h99, 4'd15, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    do_op("dbl",       8'h81, 8'h00, 4'd12, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);

    // Logic, carry-in must not matter
    do_op("xor_c0",    8'hF0, 8'h3C, 4'd6, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0, 1'b1);
    do_op("xor_c1",    8'hF0, 8'h3C, 4'd6, 1'b1, 1'b1, 8'hCC, 1'b1, 1'b0, 1'b1);
    do_op("and",       8'hF0, 8'h3C, 4'd11, 1'b1, 1'b0, 8'h30, 1'b1, 1'b0, 1'b1);
    do_op("or",        8'hF0, 8'h3C, 4'd14, 1'b1, 1'b1, 8'hFC, 1'b1, 1'b0, 1'b1);
    do_op("nota",      8'h0F, 8'hAA, 4'd0, 1'b1, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1);
    do_op("xnor",      8'h0F, 8'h0F, 4'd9, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);

    // Backpressure: DONE holds while in_valid and a keep changing
    do_op("bp", 8'hF8, 8'h0A, 4'd9, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; s = 4'd3; m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 8'(i * 37 + 5);
      tick();
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      check("bp.f", 32'(f), 32'h02);
      check("bp.cn_out_n", 32'(cn_out_n), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    check("bp.release_valid", 32'(out_valid), 32'd0);
    tick();
    check("bp.no_new_op", 32'(in_ready), 32'd1);

    // Reset mid-RUN aborts the operation
    a = 8'hFF; b = 8'h01; s = 4'd9; m = 1'b0; cn_n = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("abort.in_run", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.f", 32'(f), 32'h00);
    check("abort.cn_out_n", 32'(cn_out_n), 32'd1);
    check("abort.aeqb", 32'(aeqb), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort.stay_idle", 32'(out_valid), 32'd0);
    end
    do_op("after_abort", 8'hFF, 8'h01, 4'd9, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu181_seq.md
# alu181_seq

Parametrised, multi-cycle successor to the team's 4-bit 74181-style ALU.
- Accepts a WIDTH-bit operation through a valid/ready handshake.
- Evaluates it as WIDTH/4 cascaded 74181 slices, one slice per clock, LSB first, with the carry rippling through a register between slices.
- Presents the registered result, carry-out and A=B flag through a second valid/ready handshake.
- Sits between the tile's pin-mux/operand registers and the result readout logic.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of 4 and ≥4, otherwise elaboration error. NSLICE = WIDTH/4.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand A (active-high data)
- b  in  WIDTH  operand B
- s  in  4  function select S3..S0
- m  in  1  mode: 1 = logic, 0 = arithmetic
- cn_n  in  1  carry-in, active-low (0 = carry in); ignored when m=1
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- f  out  WIDTH  result
- cn_out_n  out  1  carry-out, active-low
- aeqb  out  1  high when f is all ones

## Operation
- Per-bit terms:
  - X = A | (B & S0) | (~B & S1)
  - Y = (A & B & S3) | (A & ~B & S2)
- Arithmetic (m=0):
  - f = X + Y + (~cn_n), computed modulo 2^WIDTH.
  - Carry-out = carry out of that WIDTH-bit sum; cn_out_n = ~carry-out.
  - Examples: S=9 gives A plus B; S=6 gives A minus B minus 1 (plus carry); S=12 gives A+A; S=15 gives A−1; S=3 gives all ones.
- Logic (m=1):
  - f = ~(X ^ Y). Examples: S=0 gives ~A; S=6 gives A^B; S=9 gives ~(A^B); S=11 gives A&B; S=14 gives A|B.
  - cn_out_n = 1; cn_n has no effect.
- aeqb = &f, evaluated on the final result in both modes.
- FSM:
  - IDLE: in_ready=1. On in_valid & in_ready, latch a, b, s, m, cn_n; carry register ← ~cn_n; slice index ← 0; go to RUN.
  - RUN: each cycle, compute slice idx (bits 4·idx+3 : 4·idx) from latched operands and the carry register. Write those bits of an internal accumulator, update the carry register, idx++. After slice NSLICE−1, load f, cn_out_n and aeqb from the accumulator and final carry; go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Inputs a, b, s, m and cn_n may change freely outside the accept cycle; only latched values are used.
- f, cn_out_n and aeqb change only on entry to DONE, and hold their values through DONE, IDLE and RUN until the next DONE entry.
- in_valid is ignored outside IDLE; out_ready is ignored outside DONE.

## Timing
- Reset, on any edge with rst=1 and in any state:
  - State → IDLE; idx → 0; carry register → 0.
  - f → 0, cn_out_n → 1, aeqb → 0, out_valid → 0.
  - in_ready = 1 in the cycle after reset.
- Reset mid-RUN or in DONE aborts the operation; no out_valid pulse follows.
- Latency: handshake in cycle t gives out_valid high from cycle t+NSLICE+1 (WIDTH=8: t+3).
- Throughput:
  - Result consumed in the first DONE cycle gives in_ready high again in cycle t+NSLICE+2.
  - Maximum rate is one operation per NSLICE+2 cycles.
- No combinational path from in_valid to in_ready, nor from out_ready to out_valid. in_ready and out_valid are decoded from registered state only.
- WIDTH=4 (NSLICE=1): exactly one RUN cycle.
- Under backpressure (out_ready=0), DONE persists indefinitely with all outputs stable.

## Test plan
- Reset: rst=1 for 2 cycles → out_valid=0, in_ready=1, f=0x00, cn_out_n=1, aeqb=0.
- Add with inter-slice carry: a=0xF8, b=0x0A, s=9, m=0, cn_n=1, handshake at cycle 0 → out_valid at cycle 3, f=0x02, cn_out_n=0, aeqb=0.
- Subtract/compare:
  - a=0x10, b=0x01, s=6, m=0, cn_n=0 → f=0x0F, cn_out_n=0.
  - a=b=0x5A, s=6, m=0, cn_n=1 → f=0xFF, cn_out_n=1, aeqb=1.
- Logic, carry ignored: a=0xF0, b=0x3C, m=1, s=6, once with cn_n=0 and once with cn_n=1 → f=0xCC, cn_out_n=1, aeqb=0 both times.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a → out_valid, f and cn_out_n stable, in_ready=0, no new operation accepted. Then out_ready=1 → in_ready=1 the next cycle.
- Reset mid-RUN: rst=1 in cycle 1 after accepting a=0xFF, b=0x01, s=9, m=0 → IDLE next cycle, out_valid stays 0, f=0x00, cn_out_n=1. A following operation completes normally.
